spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- Transmit-only SPI master (mode 0: CPOL=0, CPHA=0, MSB first) sitting directly downstream of display_controller.
- Accepts one byte per tx_start/tx_busy handshake together with a dc qualifier.
- Serialises each byte onto the display's SCK/MOSI/CS/DC pins.
- Frames every byte with its own chip-select assertion so the panel latches dc per byte.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period; must be >= 1.
- CS_SETUP, 1: clk cycles from CS low (and first MOSI bit valid) to the first SCK rising edge; must be >= 1.
- CS_HOLD, 1: clk cycles from the end of the last bit's low phase to CS high; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_start  in  1  one-cycle request; accepted only when tx_busy=0
- tx_data  in  8  byte to send; sampled on the accepting edge
- dc  in  1  data/command qualifier (0=command, 1=data); sampled with tx_data
- tx_busy  out  1  high from the edge after acceptance until the byte is complete
- spi_sck  out  1  serial clock; idles low
- spi_mosi  out  1  serial data, MSB first
- spi_cs_n  out  1  active-low chip select
- spi_dc  out  1  registered dc for the byte in flight; holds its last value while idle

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: tx_busy=0, spi_sck=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, FSM=IDLE, counters=0.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD.
- IDLE:
  - On a posedge with tx_start=1 (and reset=0), capture tx_data into a shift register and dc into spi_dc.
  - After that edge: tx_busy=1, spi_cs_n=0, spi_mosi=tx_data[7], spi_sck=0; go to SETUP with the counter loaded to CS_SETUP.
- SETUP: hold for CS_SETUP cycles, then go to SCK_HI.
- SCK_HI:
  - spi_sck=1 for CLK_DIV cycles; the slave samples on the rising edge.
  - Then go to SCK_LO. If more bits remain, the shift register advances and spi_mosi takes the next bit on the same edge that lowers spi_sck.
- SCK_LO:
  - spi_sck=0 for CLK_DIV cycles.
  - The bit counter decrements 7..0; after bit 0's low phase, go to HOLD.
  - Otherwise go back to SCK_HI.
- HOLD: spi_sck=0 and spi_mosi holds the last bit for CS_HOLD cycles; then spi_cs_n=1, tx_busy=0, FSM=IDLE.
- Exactly 8 rising edges of spi_sck per byte.
- Busy duration is tx_busy high for exactly CS_SETUP + 16*CLK_DIV + CS_HOLD cycles. The default is 34.
- Back-to-back bytes:
  - A tx_start on the first cycle tx_busy reads 0 is accepted.
  - spi_cs_n is therefore high for at least 1 cycle between bytes.
- A tx_start while tx_busy=1 is ignored: no queueing, and neither the shift register nor spi_dc changes.
- tx_data and dc may change freely after the accepting edge without affecting the byte in flight.
- Reset mid-byte:
  - The byte is aborted and all outputs return to reset values on the next edge.
  - No partial-byte completion; tx_busy drops immediately.
- A tx_start coinciding with reset is ignored.
- Counter widths are $clog2 of the largest of CLK_DIV, CS_SETUP, CS_HOLD, plus 1. The bit counter is 3 bits.
- spi_cs_n is never high while spi_sck=1. spi_sck is never high outside SCK_HI.

Test Plan:
- Reset: hold reset 2 cycles with tx_start=1 -> tx_busy=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, spi_dc=0; no transaction starts.
- Single command: defaults, tx_data=8'h01 (SW reset), dc=0 -> bench slave samples 8'h01 on 8 spi_sck rises; spi_dc=0 throughout the frame; tx_busy high exactly 34 cycles.
- Data byte with mode check: tx_data=8'hA5, dc=1, CLK_DIV=1, CS_SETUP=3, CS_HOLD=2 -> bits 1,0,1,0,0,1,0,1; spi_mosi stable for >=1 cycle before every spi_sck rise; tx_busy high 21 cycles; spi_cs_n low for those same 21 cycles.
- Back-to-back: re-assert tx_start on the first tx_busy=0 cycle with 8'hF8 then 8'h00, dc=1 -> both bytes received in order; spi_cs_n high exactly 1 cycle between frames.
- Ignored start: pulse tx_start with 8'hFF, dc=0 mid-transfer of 8'h3C, dc=1 -> slave receives only 8'h3C; spi_dc stays 1; no extra SCK edges.
- Abort: assert reset after the 3rd spi_sck rise of 8'hC3 -> next edge gives spi_cs_n=1, spi_sck=0, tx_busy=0; a following tx_start with 8'h5A completes normally (8 rises, 34 busy cycles).

Source files
------------

// File: rtl/spi_master_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_tx_if
// Description : Byte handshake between the upstream byte source (master
//               modport) and the SPI transmitter (slave modport).
//               tx_start : one-cycle request, honoured only while tx_busy=0
//               tx_data  : byte to send, sampled on the accepting edge
//               dc       : data/command qualifier, sampled with tx_data
//               tx_busy  : high while a byte is being framed and shifted
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       dc;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, output dc, input  tx_busy);
  modport slave  (input  tx_start, input  tx_data, input  dc, output tx_busy);
endinterface
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_tx
// Description : Transmit-only SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//               Each accepted byte is framed by its own chip-select assertion
//               so the panel can latch the data/command qualifier per byte.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               tx (slave)     - tx_start / tx_data / dc / tx_busy handshake
//               spi_sck        - serial clock, idles low
//               spi_mosi       - serial data, MSB first
//               spi_cs_n       - active-low chip select
//               spi_dc         - dc of the byte in flight, held while idle
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_tx #(
  parameter int CLK_DIV  = 2,  // clk cycles per SCK half-period (>= 1)
  parameter int CS_SETUP = 1,  // CS low to first SCK rise (>= 1)
  parameter int CS_HOLD  = 1   // end of last low phase to CS high (>= 1)
) (
  input  wire logic         clk,
  input  wire logic         reset,
  spi_master_tx_if.slave    tx,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              spi_dc
);

  localparam int MAX_LD = (CLK_DIV > CS_SETUP)
                          ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                          : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W  = $clog2(MAX_LD) + 1;

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;    // cycles left in the current phase
  logic [2:0]       r_bit;    // index of the bit currently on spi_mosi
  logic [6:0]       r_shift;  // bits still to be sent after the current one

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= CNT_ZERO;
      r_bit      <= 3'd0;
      r_shift    <= 7'd0;
      tx.tx_busy <= 1'b0;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_dc     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tx.tx_start) begin
            // MSB goes straight onto the pin; the shift register keeps the rest.
            r_shift    <= tx.tx_data[6:0];
            spi_mosi   <= tx.tx_data[7];
            spi_dc     <= tx.dc;
            tx.tx_busy <= 1'b1;
            spi_cs_n   <= 1'b0;
            spi_sck    <= 1'b0;
            r_bit      <= 3'd7;
            r_cnt      <= SETUP_LD;
            r_state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (r_cnt == CNT_ONE) begin
            spi_sck <= 1'b1;
            r_cnt   <= DIV_LD;
            r_state <= ST_SCK_HI;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_SCK_HI: begin
          if (r_cnt == CNT_ONE) begin
            spi_sck <= 1'b0;
            r_cnt   <= DIV_LD;
            r_state <= ST_SCK_LO;
            // Next bit changes on the falling edge so it is stable for the
            // whole low phase before the slave samples it on the next rise.
            if (r_bit != 3'd0) begin
              spi_mosi <= r_shift[6];
              r_shift  <= {r_shift[5:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_SCK_LO: begin
          if (r_cnt == CNT_ONE) begin
            if (r_bit == 3'd0) begin
              r_cnt   <= HOLD_LD;
              r_state <= ST_HOLD;
            end else begin
              r_bit   <= r_bit - 3'd1;
              spi_sck <= 1'b1;
              r_cnt   <= DIV_LD;
              r_state <= ST_SCK_HI;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        ST_HOLD: begin
          if (r_cnt == CNT_ONE) begin
            spi_cs_n   <= 1'b1;
            tx.tx_busy <= 1'b0;
            r_cnt      <= CNT_ZERO;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= CNT_ZERO;
          tx.tx_busy <= 1'b0;
          spi_sck    <= 1'b0;
          spi_cs_n   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
